conv_row_scheduler: RTL

Row-level sequencer for the multi-filter convolution layer. It walks the image top to bottom, one output row per step. For each step it selects the window of F image rows from the line buffer, pulses the conv layer's start input, and waits for the conv layer's done. It then presents the finished row index to the downstream consumer under a valid/ready handshake. One start request produces H-F+1 output rows and ends with a frame_done pulse.

---
 rtl/conv_row_scheduler_if.sv | 35 +++
 rtl/conv_row_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/conv_row_scheduler_if.sv
// rtl/conv_row_scheduler_if.sv - control/handshake bundle of conv_row_scheduler
// o_stall_cycles exists only when CONV_SCHED_PERF_EN is defined.
interface conv_row_scheduler_if #(
   parameter int RW = 6
);
   logic          i_start;
   logic          i_abort;
   logic          i_conv_done;
   logic          i_out_ready;
   logic          o_busy;
   logic          o_frame_done;
   logic [RW-1:0] o_row_sel;
   logic          o_conv_start;
   logic          o_out_valid;
   logic [RW-1:0] o_out_row;
`ifdef CONV_SCHED_PERF_EN
   logic [31:0]   o_stall_cycles;
`endif

   modport slave (
      input  i_start, i_abort, i_conv_done, i_out_ready,
      output o_busy, o_frame_done, o_row_sel, o_conv_start, o_out_valid, o_out_row
`ifdef CONV_SCHED_PERF_EN
      , o_stall_cycles
`endif
   );

   modport master (
      output i_start, i_abort, i_conv_done, i_out_ready,
      input  o_busy, o_frame_done, o_row_sel, o_conv_start, o_out_valid, o_out_row
`ifdef CONV_SCHED_PERF_EN
      , o_stall_cycles
`endif
   );
endinterface

// File: rtl/conv_row_scheduler.sv
// rtl/conv_row_scheduler.sv - row-level sequencer driving the conv layer one output row per step
// CONV_SCHED_PERF_EN adds the o_stall_cycles back-pressure counter.
module conv_row_scheduler #(
   parameter int H  = 64,
   parameter int F  = 3,
   parameter int D  = 1,
   parameter int RW = $clog2(H)
) (
   input  logic                clk,
   input  logic                reset,
   conv_row_scheduler_if.slave bus
);
   // D only documents the conv layer depth; compute time comes from i_conv_done.
   localparam logic [RW-1:0] LAST_ROW = RW'(H - F + 0 * D);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;

   state_t        r_state, w_state_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic          r_first_wait, w_first_wait_nxt;
   logic          r_frame_done, w_frame_done_nxt;
   logic          r_busy;
   logic          r_conv_start;
   logic          r_out_valid;

   always_comb begin
      w_state_nxt      = r_state;
      w_row_nxt        = r_row;
      w_first_wait_nxt = 1'b0;
      w_frame_done_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_start) begin
               w_state_nxt = LOAD;
               w_row_nxt   = '0;
            end
         end
         LOAD:  w_state_nxt = START;
         START: begin
            w_state_nxt      = WAIT;
            w_first_wait_nxt = 1'b1;
         end
         // A done left high by the previous row is ignored in the first WAIT cycle.
         WAIT: begin
            if (!r_first_wait && bus.i_conv_done)
               w_state_nxt = OUT;
         end
         OUT: begin
            if (bus.i_out_ready) begin
               if (r_row == LAST_ROW) begin
                  w_state_nxt      = IDLE;
                  w_frame_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = LOAD;
                  w_row_nxt   = r_row + RW'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (bus.i_abort && (r_state != IDLE)) begin
         w_state_nxt      = IDLE;
         w_row_nxt        = '0;
         w_frame_done_nxt = 1'b0;
         w_first_wait_nxt = 1'b0;
      end
   end

   // Outputs are decoded from the next state so they are registered yet state-aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_row        <= '0;
         r_first_wait <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_conv_start <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_row        <= w_row_nxt;
         r_first_wait <= w_first_wait_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_conv_start <= (w_state_nxt == START);
         r_out_valid  <= (w_state_nxt == OUT);
      end
   end

   assign bus.o_busy       = r_busy;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_row_sel    = r_row;
   assign bus.o_conv_start = r_conv_start;
   assign bus.o_out_valid  = r_out_valid;
   assign bus.o_out_row    = r_row;

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_cycles <= '0;
      else if ((r_state == IDLE) && bus.i_start)
         r_stall_cycles <= '0;
      else if (r_out_valid && !bus.i_out_ready && (r_stall_cycles != 32'hFFFF_FFFF))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign bus.o_stall_cycles = r_stall_cycles;
`endif
endmodule
